// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub
//   Sequential adder/subtractor. One shared 4-bit carry-lookahead slice
//   processes one nibble of the operands per clock, least significant
//   nibble first. A registered carry links the nibbles. The result and flags
//   are registered once, when the last nibble completes.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start            request, accepted only while ready=1
//   op_sub           1 = ain - bin, 0 = ain + bin (captured with start)
//   ain, bin         operands (captured with start)
//   ready            1 in IDLE and DONE (a start will be accepted)
//   busy             1 while nibbles are being processed
//   done             one-cycle pulse; result/flags were just updated
//   result           sum/difference, held until the next done
//   cout             carry out of MSB (subtract: 1 = no borrow)
//   ovf              signed overflow
//   zero             result == 0
//   dbg_state_o      current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge where start=1 and
// ready=1. A start at any other time is dropped, not queued. done is high
// for exactly one cycle, NIB+1 cycles after the request was accepted.
// Because ready is also high in DONE, a new request can be accepted in
// the same cycle as done.
module nibble_serial_addsub #(
  parameter  int WIDTH = 32,
  localparam int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Shared 4-bit carry-lookahead slice
  logic [3:0] sl_p, sl_g, sl_sum;
  logic [4:0] sl_c;

  assign sl_p    = a_q[3:0] ^ b_q[3:0];
  assign sl_g    = a_q[3:0] & b_q[3:0];
  assign sl_c[0] = carry_q;
  assign sl_c[1] = sl_g[0] | (sl_p[0] & sl_c[0]);
  assign sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & sl_c[0]);
  assign sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
                 | (sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
  assign sl_c[4] = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
                 | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
                 | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
  assign sl_sum  = sl_p ^ sl_c[3:0];

  logic last_nib;
  assign last_nib = (cnt_q == CW'(NIB - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    w_d      = w_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          // Subtraction is ain + ~bin + 1: invert B here and use the
          // initial carry as the +1.
          a_d     = ain;
          b_d     = op_sub ? ~bin : bin;
          w_d     = '0;
          carry_d = op_sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // New nibble enters at the top; after NIB shifts the first nibble
        // has moved down to bits [3:0].
        w_d     = {sl_sum, w_q[WIDTH-1:4]};
        a_d     = {4'b0000, a_q[WIDTH-1:4]};
        b_d     = {4'b0000, b_q[WIDTH-1:4]};
        carry_d = sl_c[4];
        if (last_nib) begin
          cnt_d    = '0;
          state_d  = S_DONE;
          result_d = w_d;
          cout_d   = sl_c[4];
          // sl_c[3] is the carry into the result MSB on the last nibble
          ovf_d    = sl_c[3] ^ sl_c[4];
          zero_d   = (w_d == '0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      w_q      <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      w_q      <= w_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign ready       = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign result      = result_q;
  assign cout        = cout_q;
  assign ovf         = ovf_q;
  assign zero        = zero_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
module tb_nibble_serial_addsub;

  localparam int W   = 32;
  localparam int NIB = W / 4;
  localparam int LAT = NIB + 1;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op_sub;
  logic [W-1:0] ain, bin;
  logic         ready, busy, done, cout, ovf, zero;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  // Scoreboard entries are packed {cout, ovf, zero, result}
  logic [W+2:0] exp_q[$];

  always #5 clk = ~clk;

  nibble_serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub),
    .ain(ain), .bin(bin), .ready(ready), .busy(busy), .done(done),
    .result(result), .cout(cout), .ovf(ovf), .zero(zero),
    .dbg_state_o(dbg_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Plain integer arithmetic: unsigned range for carry/borrow, signed range
  // for overflow.
  function automatic logic [W+2:0] model(input logic op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint ua, ub, sa, sb, us, ss, smax, smin;
    logic [W-1:0] r;
    logic c, o;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    if (op) begin
      us = ua - ub; ss = sa - sb; c = (ua >= ub);
    end else begin
      us = ua + ub; ss = sa + sb; c = (us >= (longint'(1) <<< W));
    end
    r = us[W-1:0];
    o = (ss > smax) || (ss < smin);
    return {c, o, (r == '0), r};
  endfunction

  // ---------------- driver ----------------
  // Issues one request from idle and waits for done; lat counts rising
  // edges from the cycle start was driven until done is seen.
  task automatic do_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W+2:0] obs, output int lat);
    @(negedge clk);
    start = 1'b1; op_sub = op; ain = a; bin = b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0; ain = $urandom; bin = $urandom; op_sub = 1'($urandom_range(0, 1));
    while (done !== 1'b1 && lat < LAT + 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    obs = {cout, ovf, zero, result};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; ain = '0; bin = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({ready, busy, done, cout, ovf, zero} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_flags got rdy/busy/done/c/o/z=%b want 100000",
               {ready, busy, done, cout, ovf, zero});
    end
    total++;
    if (result !== '0) begin
      bad++; $display("FAIL reset_result got %h want 0", result);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic         ops[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] as[4]   = '{32'h0000_0005, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [W-1:0] bs[4]   = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
    logic [W+2:0] exps[4] = '{{1'b1, 1'b0, 1'b0, 32'h0000_0002},
                              {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF},
                              {1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF},
                              {1'b1, 1'b0, 1'b1, 32'h0000_0000}};
    logic [W+2:0] obs;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], obs, lat);
      total++;
      if (obs !== exps[i]) begin
        bad++;
        $display("FAIL directed_%0d got c/o/z/res=%h want %h", i, obs, exps[i]);
      end
      total++;
      if (lat != LAT) begin
        bad++; $display("FAIL directed_latency_%0d got %0d want %0d", i, lat, LAT);
      end
    end
  endtask

  task automatic test_hold();
    logic [W+2:0] obs, e;
    logic [W-1:0] a, b;
    logic op;
    int lat, n;
    do_op(1'b0, 32'h1234_5678, 32'h1111_1111, obs, lat);
    // idle: result held, no done, ready
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (result !== 32'h2345_6789 || done !== 1'b0 || ready !== 1'b1) begin
        bad++;
        $display("FAIL hold_idle_%0d got res=%h done=%b ready=%b want 23456789/0/1",
                 i, result, done, ready);
      end
    end
    // next run: result must stay put until the new done
    a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
    e = model(op, a, b);
    start = 1'b1; op_sub = op; ain = a; bin = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < LAT + 20) begin
      total++;
      if (result !== 32'h2345_6789 || busy !== 1'b1) begin
        bad++;
        $display("FAIL hold_run_%0d got res=%h busy=%b want 23456789/1", n, result, busy);
      end
      @(posedge clk); n++;
      @(negedge clk);
    end
    total++;
    if ({cout, ovf, zero, result} !== e) begin
      bad++; $display("FAIL hold_next got %h want %h", {cout, ovf, zero, result}, e);
    end
  endtask

  task automatic test_busy_ignore();
    logic [W+2:0] e;
    logic [W-1:0] a, b;
    logic op;
    int lat, extra;
    a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
    e = model(op, a, b);
    @(negedge clk);
    start = 1'b1; op_sub = op; ain = a; bin = b;
    @(posedge clk); lat = 1;
    @(negedge clk);
    while (done !== 1'b1 && lat < LAT + 20) begin
      start = 1'($urandom_range(0, 1)); ain = $urandom; bin = $urandom;
      op_sub = 1'($urandom_range(0, 1));
      @(posedge clk); lat++;
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if ({cout, ovf, zero, result} !== e) begin
      bad++; $display("FAIL busy_ignore_result got %h want %h", {cout, ovf, zero, result}, e);
    end
    total++;
    if (lat != LAT) begin
      bad++; $display("FAIL busy_ignore_latency got %0d want %0d", lat, LAT);
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++; $display("FAIL busy_ignore_extra_done got %0d want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [W+2:0] e, obs;
    int got, pushed, cyc, last;
    got = 0; pushed = 0; cyc = 0; last = -1;
    exp_q.delete();
    @(negedge clk);
    while (got < 6 && cyc < 200) begin
      if (done === 1'b1) begin
        obs = {cout, ovf, zero, result};
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_unexpected_done got %h want none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            bad++; $display("FAIL b2b_result_%0d got %h want %h", got, obs, e);
          end
        end
        if (last >= 0) begin
          total++;
          if (cyc - last != LAT) begin
            bad++; $display("FAIL b2b_period got %0d want %0d", cyc - last, LAT);
          end
        end
        last = cyc; got++;
      end
      ain = $urandom; bin = $urandom; op_sub = 1'($urandom_range(0, 1));
      if (ready === 1'b1) begin
        if (pushed < 6) begin
          start = 1'b1;
          exp_q.push_back(model(op_sub, ain, bin));
          pushed++;
        end else begin
          start = 1'b0;
        end
      end else begin
        start = 1'b1;
      end
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (got != 6 || exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_count got %0d dones (%0d left) want 6 (0 left)", got, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W+2:0] obs;
    int lat, seen;
    do_op(1'b0, 32'h0000_0005, 32'h0000_0003, obs, lat);
    @(negedge clk);
    start = 1'b1; op_sub = 1'b1; ain = 32'hDEAD_BEEF; bin = 32'h0000_0001;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({ready, busy, done, cout, ovf, zero} !== 6'b100000 || result !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs got rdy/busy/done/c/o/z=%b res=%h want 100000/0",
               {ready, busy, done, cout, ovf, zero}, result);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (done === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL mid_reset_done got %0d pulses want 0", seen);
    end
  endtask

  task automatic test_random();
    logic [W+2:0] obs, e;
    logic [W-1:0] a, b;
    logic op;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = a;
        1: a = '0;
        2: b = {W{1'b1}};
        3: a = {1'b1, {(W - 1){1'b0}}};
        default: ;
      endcase
      e = model(op, a, b);
      do_op(op, a, b, obs, lat);
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL random_%0d op=%b a=%h b=%h got %h want %h", i, op, a, b, obs, e);
      end
      total++;
      if (lat != LAT) begin
        bad++; $display("FAIL random_latency_%0d got %0d want %0d", i, lat, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
